// File: rtl/msrv32_pkg.sv
// ============================================================================
//  Module      : msrv32_pkg
//  Description : Shared constants for the RV32I store unit: funct3 store
//                codes, AHB HTRANS encodings and byte-lane mask values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package msrv32_pkg;

    // Store width codes carried in funct3 (only bits [1:0] select the width)
    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    // AHB-Lite transfer types used by a single-beat write master
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Byte-lane write strobes, bit n enables byte n
    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

endpackage : msrv32_pkg

`default_nettype wire

// File: rtl/ms_rv32_store_unit_if.sv
// ============================================================================
//  Module      : ms_rv32_store_unit_if
//  Description : Bundle of execute-stage request signals and AHB-Lite write
//                master signals around the store unit. The "master" modport
//                is the side presenting the store request (execute stage),
//                the "slave" modport is the store unit itself.
//                Optional macro MS_RV32_MISALIGN_CHECK_EN adds the
//                misaligned_store_out flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface ms_rv32_store_unit_if;

    logic [2:0]  funct3_in;
    logic [31:0] iadder_in;
    logic [31:0] rs2_in;
    logic        mem_wr_req_in;
    logic        ahb_ready_in;

    logic [31:0] ms_riscv32_mp_dmdata_out;
    logic [31:0] ms_riscv32_mp_dmaddr_out;
    logic [3:0]  ms_riscv32_mp_dmwr_mask_out;
    logic        ms_riscv32_mp_dmwr_req_out;
    logic [1:0]  ahb_htrans_out;
`ifdef MS_RV32_MISALIGN_CHECK_EN
    logic        misaligned_store_out;
`endif

`ifdef MS_RV32_MISALIGN_CHECK_EN
    modport master (
        output funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
        input  ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmaddr_out,
               ms_riscv32_mp_dmwr_mask_out, ms_riscv32_mp_dmwr_req_out,
               ahb_htrans_out, misaligned_store_out
    );
    modport slave (
        input  funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
        output ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmaddr_out,
               ms_riscv32_mp_dmwr_mask_out, ms_riscv32_mp_dmwr_req_out,
               ahb_htrans_out, misaligned_store_out
    );
`else
    modport master (
        output funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
        input  ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmaddr_out,
               ms_riscv32_mp_dmwr_mask_out, ms_riscv32_mp_dmwr_req_out,
               ahb_htrans_out
    );
    modport slave (
        input  funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
        output ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmaddr_out,
               ms_riscv32_mp_dmwr_mask_out, ms_riscv32_mp_dmwr_req_out,
               ahb_htrans_out
    );
`endif

endinterface : ms_rv32_store_unit_if

`default_nettype wire

// File: rtl/msrv32_store_align.sv
// ============================================================================
//  Module      : msrv32_store_align
//  Description : Combinational store-data replication and byte-lane mask
//                generation from the store width and the low address bits.
//                With MS_RV32_MISALIGN_CHECK_EN defined it also flags
//                misaligned halfword/word accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module msrv32_store_align
    import msrv32_pkg::*;
(
    input  wire logic [1:0]  width_sel_i,   // funct3[1:0]
    input  wire logic [1:0]  byte_off_i,    // effective address [1:0]
    input  wire logic [31:0] rs2_i,
    output logic      [31:0] data_o,
    output logic      [3:0]  mask_o
`ifdef MS_RV32_MISALIGN_CHECK_EN
    ,
    output logic             misaligned_o
`endif
);

    logic w_misaligned;

    // Replicate the store operand across every lane it may land in and pick the lanes
    always_comb begin
        data_o       = rs2_i;
        mask_o       = MASK_WORD;
        w_misaligned = 1'b0;
        if (width_sel_i == FUNCT3_SB[1:0]) begin
            data_o = {4{rs2_i[7:0]}};
            mask_o = MASK_BYTE0 << byte_off_i;
        end else if (width_sel_i == FUNCT3_SH[1:0]) begin
            data_o       = {2{rs2_i[15:0]}};
            mask_o       = byte_off_i[1] ? MASK_HALF_HI : MASK_HALF_LO;
            w_misaligned = byte_off_i[0];
        end else begin
            // 2'b10 and 2'b11 both decode as a full word
            w_misaligned = (byte_off_i != 2'b00);
        end
    end

`ifdef MS_RV32_MISALIGN_CHECK_EN
    assign misaligned_o = w_misaligned;
`else
    // Misalignment is not reported in this build; keep the term for readability only
    logic w_misaligned_unused;
    assign w_misaligned_unused = w_misaligned;
`endif

endmodule : msrv32_store_align

`default_nettype wire

// File: rtl/ms_rv32_store_unit.sv
// ============================================================================
//  Module      : ms_rv32_store_unit
//  Description : RV32I store unit. Drives the AHB-Lite address phase
//                combinationally (word-aligned address, byte strobes, write
//                request, HTRANS) and registers the aligned write data for
//                the following data phase.
//                Optional macro MS_RV32_MISALIGN_CHECK_EN suppresses and
//                flags misaligned SH/SW accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ms_rv32_store_unit
    import msrv32_pkg::*;
(
    input  wire logic           ms_riscv32_mp_clk_in,
    input  wire logic           ms_riscv32_mp_rst_in,
    ms_rv32_store_unit_if.slave bus
);

    logic [31:0] w_aligned_data;
    logic [3:0]  w_aligned_mask;
    logic        w_issue;
    logic [31:0] data_d;
    logic [31:0] data_q;

    msrv32_store_align u_align (
        .width_sel_i  (bus.funct3_in[1:0]),
        .byte_off_i   (bus.iadder_in[1:0]),
        .rs2_i        (bus.rs2_in),
        .data_o       (w_aligned_data),
        .mask_o       (w_aligned_mask)
`ifdef MS_RV32_MISALIGN_CHECK_EN
        ,
        .misaligned_o (bus.misaligned_store_out)
`endif
    );

    // A write is presented only when requested, out of reset and (if checked) aligned
`ifdef MS_RV32_MISALIGN_CHECK_EN
    assign w_issue = bus.mem_wr_req_in & ~ms_riscv32_mp_rst_in & ~bus.misaligned_store_out;
`else
    assign w_issue = bus.mem_wr_req_in & ~ms_riscv32_mp_rst_in;
`endif

    // Address phase: purely combinational from the request inputs
    always_comb begin
        bus.ms_riscv32_mp_dmaddr_out    = {bus.iadder_in[31:2], 2'b00};
        bus.ms_riscv32_mp_dmwr_req_out  = w_issue;
        bus.ms_riscv32_mp_dmwr_mask_out = w_issue ? w_aligned_mask : MASK_NONE;
        bus.ahb_htrans_out              = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    // Capture write data only when the address phase is accepted (HREADY high)
    always_comb begin
        data_d = data_q;
        if (w_issue && bus.ahb_ready_in) begin
            data_d = w_aligned_data;
        end
    end

    // Data-phase register, cleared on reset
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.ms_riscv32_mp_dmdata_out = data_q;

endmodule : ms_rv32_store_unit

`default_nettype wire

// File: tb/tb_ms_rv32_store_unit.sv
// ============================================================================
//  Module      : tb_ms_rv32_store_unit
//  Description : Self-checking bench for ms_rv32_store_unit: directed
//                scenarios followed by random stores, compared against a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ms_rv32_store_unit;

    logic clk = 1'b0;
    logic rst;

    ms_rv32_store_unit_if bus ();

    ms_rv32_store_unit dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_data;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: apply inputs, check the address phase, clock, check the data phase
    task automatic step(input logic r, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic req, input logic rdy);
        logic [31:0] ed;
        logic [3:0]  em;
        logic        mis;
        logic        go;
        @(negedge clk);
        rst               = r;
        bus.funct3_in     = f;
        bus.iadder_in     = a;
        bus.rs2_in        = d;
        bus.mem_wr_req_in = req;
        bus.ahb_ready_in  = rdy;
        #1;
        // Reference model from the store rules, using arithmetic replication
        if (f[1]) begin
            ed  = d;
            em  = 4'hF;
            mis = (a % 4) != 0;
        end else if (f[0]) begin
            ed  = {16'h0, d[15:0]} * 32'h0001_0001;
            em  = (a % 4 >= 2) ? 4'hC : 4'h3;
            mis = (a % 2) != 0;
        end else begin
            ed  = {24'h0, d[7:0]} * 32'h0101_0101;
            em  = 4'(1 << (a % 4));
            mis = 1'b0;
        end
        mis = mis & req;
        go  = req & ~r;
`ifdef MS_RV32_MISALIGN_CHECK_EN
        go  = go & ~mis;
        check_val("misaligned", {31'h0, bus.misaligned_store_out}, {31'h0, mis});
`endif
        check_val("dmaddr",  bus.ms_riscv32_mp_dmaddr_out, a & 32'hFFFF_FFFC);
        check_val("wr_req",  {31'h0, bus.ms_riscv32_mp_dmwr_req_out}, {31'h0, go});
        check_val("wr_mask", {28'h0, bus.ms_riscv32_mp_dmwr_mask_out}, go ? {28'h0, em} : 32'h0);
        check_val("htrans",  {30'h0, bus.ahb_htrans_out}, go ? 32'h2 : 32'h0);
        @(posedge clk);
        if (r)              exp_data = 32'h0;
        else if (go && rdy) exp_data = ed;
        #1;
        check_val("dmdata", bus.ms_riscv32_mp_dmdata_out, exp_data);
    endtask

    initial begin
        rst               = 1'b1;
        bus.funct3_in     = 3'b010;
        bus.iadder_in     = 32'h0;
        bus.rs2_in        = 32'h0;
        bus.mem_wr_req_in = 1'b0;
        bus.ahb_ready_in  = 1'b1;
        exp_data          = 32'h0;

        // Reset with an active request: nothing issued, data cleared
        step(1'b1, 3'b010, 32'h0000_0004, 32'h1234_5678, 1'b1, 1'b1);
        // SB / SH / SW directed cases
        step(1'b0, 3'b000, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b1);
        step(1'b0, 3'b001, 32'h0000_0002, 32'h0000_FFFF, 1'b1, 1'b1);
        step(1'b0, 3'b010, 32'h0000_0004, 32'hFFFF_FFFF, 1'b1, 1'b1);
        // Distinct data so the wait-state hold is observable
        step(1'b0, 3'b000, 32'h0000_0013, 32'h0000_005A, 1'b1, 1'b1);
        // Wait state then acceptance
        step(1'b0, 3'b010, 32'h0000_0008, 32'hAAAA_AAAA, 1'b1, 1'b0);
        step(1'b0, 3'b010, 32'h0000_0008, 32'hAAAA_AAAA, 1'b1, 1'b1);
        // Idle cycle
        step(1'b0, 3'b010, 32'h0000_0010, 32'h5555_5555, 1'b0, 1'b1);
        // Misaligned word and halfword
        step(1'b0, 3'b010, 32'h0000_0006, 32'h0BAD_F00D, 1'b1, 1'b1);
        step(1'b0, 3'b001, 32'h0000_0003, 32'h0000_BEEF, 1'b1, 1'b1);
        // funct3[2] ignored: 3'b100 behaves as SB
        step(1'b0, 3'b100, 32'h0000_0002, 32'h0000_00C3, 1'b1, 1'b1);
        // Reset mid-transfer clears the data register
        step(1'b1, 3'b010, 32'h0000_0020, 32'h7777_7777, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 3'($urandom_range(0, 7)),
                 $urandom,
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ms_rv32_store_unit

`default_nettype wire
